// File: rtl/regfile_sequencer.sv
// ---------------------------------------------------------------------------
// regfile_sequencer
//   Multi-cycle control unit for a 4 x DATA_W register file. Fetches 8-bit
//   instructions over a req/ack handshake, decodes them, reads operands from
//   the register file, computes with a small internal ALU and writes back.
//
//   Instruction byte: op = ir[7:4], rd = ir[3:2], rs = ir[1:0].
//   LDI / JMP / JZ carry a second (immediate) byte.
//
// Optional feature (macro REGFILE_SEQ_STEP_EN):
//   Adds input `step`. After every writeback and every completed jump / NOP
//   the FSM parks in PAUSE (busy, no request) until step is seen high.
//   Without the macro there is no step port and execution is free-running.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   start               pulse in IDLE begins execution at pc 0
//   step                (REGFILE_SEQ_STEP_EN only) release from PAUSE
//   imem_req/addr       fetch request and address (address is the pc)
//   imem_ack/data       fetch completion and fetched byte
//   rf_ra, rf_rb        read addresses (rd, rs of the current instruction)
//   rf_a_data/b_data    combinational read data for ports A and B
//   rf_wa/wd/we         write port (we high only in writeback)
//   busy                high in every state but IDLE and HALT
//   halted              high in HALT
//   illegal             one-cycle pulse while decoding opcodes B..E
//   zflag               zero flag of the last ALU operation
// ---------------------------------------------------------------------------
module regfile_sequencer #(
    parameter int PC_W   = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef REGFILE_SEQ_STEP_EN
    input  logic              step,
`endif
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [7:0]        imem_data,
    output logic [1:0]        rf_ra,
    output logic [1:0]        rf_rb,
    input  logic [DATA_W-1:0] rf_a_data,
    input  logic [DATA_W-1:0] rf_b_data,
    output logic [1:0]        rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              rf_we,
    output logic              busy,
    output logic              halted,
    output logic              illegal,
    output logic              zflag
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_AND = 4'h4;
    localparam logic [3:0] OP_OR  = 4'h5;
    localparam logic [3:0] OP_XOR = 4'h6;
    localparam logic [3:0] OP_NOT = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_FETCH_IMM,
        S_EXEC,
        S_WB,
        S_HALT
`ifdef REGFILE_SEQ_STEP_EN
        , S_PAUSE
`endif
    } state_t;

    // Where an instruction goes once it has fully retired.
`ifdef REGFILE_SEQ_STEP_EN
    localparam state_t S_RETIRE = S_PAUSE;
`else
    localparam state_t S_RETIRE = S_FETCH;
`endif

    state_t            state, state_n;
    logic [PC_W-1:0]   pc;
    logic [7:0]        ir;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] alu;
    logic              alu_sets_z;

    logic [3:0] op;
    assign op = ir[7:4];

    // ---------------------------------------------------------------- ALU
    always_comb begin
        alu        = rf_a_data;
        alu_sets_z = 1'b0;
        case (op)
            OP_MOV: alu = rf_b_data;
            OP_ADD: begin alu = rf_a_data + rf_b_data;  alu_sets_z = 1'b1; end
            OP_SUB: begin alu = rf_a_data - rf_b_data;  alu_sets_z = 1'b1; end
            OP_AND: begin alu = rf_a_data & rf_b_data;  alu_sets_z = 1'b1; end
            OP_OR:  begin alu = rf_a_data | rf_b_data;  alu_sets_z = 1'b1; end
            OP_XOR: begin alu = rf_a_data ^ rf_b_data;  alu_sets_z = 1'b1; end
            OP_NOT: begin alu = ~rf_b_data;             alu_sets_z = 1'b1; end
            default: ;
        endcase
    end

    // ------------------------------------------------------ state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // ---------------------------------------------- next state and outputs
    always_comb begin
        state_n  = state;
        imem_req = 1'b0;
        rf_we    = 1'b0;
        busy     = 1'b1;
        halted   = 1'b0;
        illegal  = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_n = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_n = S_DECODE;
            end
            S_DECODE: begin
                case (op)
                    OP_LDI, OP_JMP, OP_JZ: state_n = S_FETCH_IMM;
                    OP_HLT:                state_n = S_HALT;
                    OP_NOP:                state_n = S_RETIRE;
                    4'hB, 4'hC, 4'hD, 4'hE: begin
                        illegal = 1'b1;
                        state_n = S_RETIRE;
                    end
                    default:               state_n = S_EXEC;
                endcase
            end
            S_FETCH_IMM: begin
                imem_req = 1'b1;
                if (imem_ack) state_n = (op == OP_LDI) ? S_WB : S_RETIRE;
            end
            S_EXEC: state_n = S_WB;
            S_WB: begin
                rf_we   = 1'b1;
                state_n = S_RETIRE;
            end
            S_HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
`ifdef REGFILE_SEQ_STEP_EN
            S_PAUSE: begin
                if (step) state_n = S_FETCH;
            end
`endif
            default: state_n = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= '0;
            ir     <= '0;
            result <= '0;
            zflag  <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ack) begin
                        ir <= imem_data;
                        pc <= pc + PC_W'(1);
                    end
                end
                S_FETCH_IMM: begin
                    if (imem_ack) begin
                        // Taken jumps override the post-increment with the immediate.
                        if (op == OP_JMP || (op == OP_JZ && zflag))
                            pc <= PC_W'(imem_data);
                        else
                            pc <= pc + PC_W'(1);
                        if (op == OP_LDI)
                            result <= imem_data[DATA_W-1:0];
                    end
                end
                S_EXEC: begin
                    // Operands are sampled here; the write lands a cycle later
                    // in WB, so rd==rs reads the pre-write value.
                    result <= alu;
                    if (alu_sets_z) zflag <= (alu == '0);
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = pc;
    assign rf_ra     = ir[3:2];
    assign rf_rb     = ir[1:0];
    assign rf_wa     = ir[3:2];
    assign rf_wd     = result;

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Multi-cycle control unit for the 4-entry x 4-bit register file (two combinational read ports, one clocked write port with enable).
- Fetches 8-bit instructions over a req/ack instruction-memory handshake and decodes them.
- Drives the register-file read/write addresses, computes results with an internal 4-bit ALU, and sequences writeback.
- Sits between instruction memory and the register file; it is the only writer of the register file.

Parameters:
- PC_W, 8, program counter and instruction-memory address width.
- DATA_W, 4, register and ALU data width; the register file is fixed at 4 entries.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle pulse; begins execution at PC 0 from IDLE
- imem_req  output  1  instruction fetch request
- imem_addr  output  PC_W  fetch address (equals pc)
- imem_ack  input  1  fetch data valid this cycle
- imem_data  input  8  instruction or immediate byte
- rf_ra  output  2  register-file read address, port A (rd)
- rf_rb  output  2  register-file read address, port B (rs)
- rf_a_data  input  DATA_W  register-file read data, port A
- rf_b_data  input  DATA_W  register-file read data, port B
- rf_wa  output  2  register-file write address
- rf_wd  output  DATA_W  register-file write data
- rf_we  output  1  register-file write enable
- busy  output  1  high in any state except IDLE and HALT
- halted  output  1  high in HALT
- illegal  output  1  one-cycle pulse on an undefined opcode
- zflag  output  1  zero flag from the last ALU operation

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst, and dominates all other inputs.
  - After the reset edge: state=IDLE, pc=0, ir=0, result=0, zflag=0, and every output is 0.
  - Reset during a pending fetch abandons the fetch. Any later imem_ack is ignored.
- Instruction format: op=ir[7:4], rd=ir[3:2], rs=ir[1:0]. Opcodes:
  - 0 NOP
  - 1 MOV: rd<=rs
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR: rd<=rd op rs
  - 7 NOT: rd<=~rs
  - 8 LDI: rd<=imm[3:0]
  - 9 JMP: pc<=imm
  - A JZ: pc<=imm if zflag
  - F HLT
  - B-E illegal: pulse illegal, then execute as NOP.
- LDI, JMP and JZ are two bytes; the second byte is the immediate.
- Arithmetic is modulo 2^DATA_W; carry is discarded. ADD..NOT update zflag=(result==0). MOV, LDI and jumps leave zflag unchanged.
- States:
  - IDLE: start -> FETCH. start in any other state is ignored.
  - FETCH: imem_req=1, imem_addr=pc. Waits indefinitely. On imem_ack: ir<=imem_data, pc<=pc+1 (wraps 255->0), -> DECODE. imem_req is low the cycle after ack is sampled.
  - DECODE: LDI/JMP/JZ -> FETCH_IMM; HLT -> HALT; NOP/illegal -> FETCH; others -> EXEC.
  - FETCH_IMM: same handshake as FETCH. On ack: imm<=imem_data, pc<=pc+1.
    - JMP, or JZ with zflag=1: pc<=imm, -> FETCH.
    - JZ with zflag=0: -> FETCH.
    - LDI: result<=imm[3:0], -> WB.
  - EXEC: sample rf_a_data/rf_b_data, result<=ALU, update zflag, -> WB.
  - WB: rf_we=1 for exactly this cycle, rf_wa=rd, rf_wd=result, -> FETCH.
  - HALT: stays until rst; halted=1.
- rf_ra=rd and rf_rb=rs are driven from ir in all states; they are 0 after reset.
- rf_we is 1 only in WB.
- Latency from ack to next imem_req, register op: DECODE, EXEC, WB, then FETCH = 4 cycles. LDI: DECODE + immediate fetch + WB.
- When rd==rs, the read returns the pre-write value: the write occurs only in WB, after reads are sampled in EXEC.

Optional Feature:
- Macro: REGFILE_SEQ_STEP_EN.
- Defined: adds input step (1 bit). After every WB and after every completed jump/NOP, the FSM enters PAUSE (busy=1, no request) until step=1, then goes to FETCH. step in other states is ignored.
- Undefined: no step port and no PAUSE state; execution is free-running.

Test Plan:
- Reset then start; memory with 1-cycle ack returns 0x81, 0x05 (LDI r0,5) -> one WB cycle with rf_we=1, rf_wa=0, rf_wd=5; pc=2.
- r0=5, r1=3; ADD r0,r1 (0x21) -> rf_wd=8, zflag=0. Then SUB r0,r0 (0x30) -> rf_wd=0, zflag=1.
- zflag=1; JZ 0x10 (0xA0, 0x10) -> next imem_addr=0x10. Repeat with zflag=0 -> next imem_addr=pc+2.
- imem_ack delayed 5 cycles -> imem_req and imem_addr held stable for 5 cycles; no rf_we.
- Opcode 0xC3 -> illegal pulses 1 cycle, no write. HLT (0xF0) -> halted=1, busy=0, no further requests until rst.
- rst asserted mid-FETCH -> outputs 0 on next edge; a following imem_ack is ignored; state stays IDLE.
